// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: shared FSM encodings and default parameters for the load/store unit
package exu_lsu_pkg;
  localparam int LSU_ADDR_W = 16;
  localparam int LSU_MEM_LAT = 1;
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_ACC  = 2'd1;
  localparam lsu_state_t S_WAIT = 2'd2;
  localparam lsu_state_t S_RESP = 2'd3;
endpackage

// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit bridging AGU requests to a local word-wide data SRAM
// AGU side: hs_ag4ls_val/i_ls_* request in, hs_ls4ag_rdy pulse with o_ls_rdat/o_ls_err out.
// SRAM side: o_mem_cs/o_mem_we/o_mem_adr/o_mem_wdat out, i_mem_rdat in (MEM_LAT cycles after cs).
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int MEM_LAT = LSU_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_ag4ls_val,
  output logic              hs_ls4ag_rdy,
  input  logic [31:0]       i_ls_adr,
  input  logic [31:0]       i_ls_wdat,
  input  logic [3:0]        i_ls_wen,
  input  logic              i_ls_ren,
  output logic [31:0]       o_ls_rdat,
  output logic              o_ls_err,
  output logic              o_mem_cs,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-3:0] o_mem_adr,
  output logic [31:0]       o_mem_wdat,
  input  logic [31:0]       i_mem_rdat
);
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  lsu_state_t state;
  logic [ADDR_W-3:0] adr_q;
  logic [31:0] wdat_q;
  logic [3:0] wen_q;
  logic ren_q, err_q;
  logic [1:0] cnt;
  logic oor, bad, nop, done;
  always_comb begin
    oor = (i_ls_adr >> ADDR_W) != 32'd0;
    bad = oor | (i_ls_ren & |i_ls_wen);
    nop = ~i_ls_ren & ~|i_ls_wen;
    done = cnt == LAT_M1;
    hs_ls4ag_rdy = state == S_RESP;
    o_ls_err = hs_ls4ag_rdy & err_q;
    o_mem_cs = state == S_ACC;
    o_mem_we = o_mem_cs ? wen_q : 4'd0;
    o_mem_adr = adr_q;
    o_mem_wdat = wdat_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      adr_q <= '0;
      wdat_q <= '0;
      wen_q <= '0;
      ren_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      o_ls_rdat <= '0;
    end else begin
      case (state)
        S_IDLE: if (hs_ag4ls_val) begin
          adr_q <= i_ls_adr[ADDR_W-1:2];
          wdat_q <= i_ls_wdat;
          wen_q <= i_ls_wen;
          ren_q <= i_ls_ren;
          err_q <= bad;
          if (bad & i_ls_ren) o_ls_rdat <= '0;
          state <= (bad | nop) ? S_RESP : S_ACC;
        end
        S_ACC: begin
          cnt <= '0;
          state <= ren_q ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          // counter parks on its final value so it never wraps within an access
          cnt <= done ? cnt : cnt + 2'd1;
          if (done) begin
            o_ls_rdat <= i_mem_rdat;
            state <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: scoreboard bench for exu_lsu with MEM_LAT=1 (unit 0) and MEM_LAT=4 (unit 1)
module tb_exu_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] val, rdy, ren, err, cs;
  logic [1:0][31:0] adr, wdat, rdat, mwdat, mrdat;
  logic [1:0][3:0] wen, mwe;
  logic [1:0][13:0] madr;
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : u
      exu_lsu #(.ADDR_W(16), .MEM_LAT(g == 0 ? 1 : 4)) dut (
        .clk(clk),
        .rst(rst),
        .hs_ag4ls_val(val[g]),
        .hs_ls4ag_rdy(rdy[g]),
        .i_ls_adr(adr[g]),
        .i_ls_wdat(wdat[g]),
        .i_ls_wen(wen[g]),
        .i_ls_ren(ren[g]),
        .o_ls_rdat(rdat[g]),
        .o_ls_err(err[g]),
        .o_mem_cs(cs[g]),
        .o_mem_we(mwe[g]),
        .o_mem_adr(madr[g]),
        .o_mem_wdat(mwdat[g]),
        .i_mem_rdat(mrdat[g])
      );
    end
  endgenerate
  logic [31:0] mem [2][16384];
  logic [31:0] pipe [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k]) begin
        pipe[k][0] <= mem[k][madr[k]];
        for (int b = 0; b < 4; b++) if (mwe[k][b]) mem[k][madr[k]][8*b +: 8] <= mwdat[k][8*b +: 8];
      end
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mrdat[0] = pipe[0][0];
  assign mrdat[1] = pipe[1][3];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nvec = 0;
  int nerr = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  typedef struct {
    int k;
    int due;
    logic err;
    logic [31:0] rdat;
    logic chk_rd;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdy[k]) begin
        if (q.size() == 0) check("spurious_rdy", 32'd1, 32'd0);
        else begin
          e_m = q.pop_front();
          check("unit", 32'(k), 32'(e_m.k));
          check("latency", 32'(cyc), 32'(e_m.due));
          check("err", 32'(err[k]), 32'(e_m.err));
          if (e_m.chk_rd) check("rdat", rdat[k], e_m.rdat);
        end
      end
    end
  end
  task automatic req(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                     input logic rd, input logic e, input logic [31:0] erd, input logic crd,
                     input int lat, input logic ecs);
    int n;
    logic saw;
    @(negedge clk);
    adr[k] = a;
    wdat[k] = wd;
    wen[k] = we;
    ren[k] = rd;
    val[k] = 1'b1;
    q.push_back('{k, cyc + lat, e, erd, crd});
    saw = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (cs[k]) begin
        saw = 1'b1;
        check("cs_cycle", 32'(n), 32'd1);
        check("mem_adr", 32'(madr[k]), 32'(a[15:2]));
        check("mem_we", 32'(mwe[k]), 32'(we));
      end
    end while (!rdy[k] && n < 20);
    val[k] = 1'b0;
    check("cs_seen", 32'(saw), 32'(ecs));
    if (!rdy[k]) check("timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    val = '0;
    ren = '0;
    adr = '0;
    wdat = '0;
    wen = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16384; i++) mem[k][i] = 32'h0;
      for (int i = 0; i < 4; i++) pipe[k][i] = 32'h0;
      mem[k][16'h10] = 32'hDEADBEEF;
      mem[k][16'h11] = 32'h12345678;
      mem[k][16383] = 32'hCAFEF00D;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_rdy", 32'(rdy[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_cs", 32'(cs[k]), 32'd0);
      check("rst_we", 32'(mwe[k]), 32'd0);
      check("rst_rdat", rdat[k], 32'd0);
      check("rst_madr", 32'(madr[k]), 32'd0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    req(0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 3, 1'b1);
    req(0, 32'h43, 32'hAB000000, 4'h8, 1'b0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
    req(0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'hABADBEEF, 1'b1, 3, 1'b1);
    req(0, 32'h00010000, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1, 1'b0);
    req(0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, 1'b1, 3, 1'b1);
    req(0, 32'h44, 32'h1, 4'h1, 1'b1, 1'b1, 32'h0, 1'b1, 1, 1'b0);
    req(0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678, 1'b1, 3, 1'b1);
    req(0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1, 1'b0);
    req(0, 32'h80000000, 32'hFF, 4'hF, 1'b0, 1'b1, 32'h12345678, 1'b1, 1, 1'b0);
    req(0, 32'hFFFC, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 3, 1'b1);
    req(0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'hABADBEEF, 1'b1, 3, 1'b1);
    req(1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 6, 1'b1);
    req(1, 32'h80, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
    req(1, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 32'h55AA55AA, 1'b1, 6, 1'b1);
    @(negedge clk);
    adr[1] = 32'h40;
    wen[1] = 4'h0;
    ren[1] = 1'b1;
    val[1] = 1'b1;
    repeat (3) @(negedge clk);
    val[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(rdy[1]), 32'd0);
    check("mid_rst_err", 32'(err[1]), 32'd0);
    check("mid_rst_cs", 32'(cs[1]), 32'd0);
    check("mid_rst_rdat", rdat[1], 32'd0);
    check("mid_rst_madr", 32'(madr[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    req(1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 6, 1'b1);
    repeat (4) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
